// File: rtl/display_scanout.sv
// display_scanout
//   Scans the front framebuffer out of system memory and streams its pixels,
//   in order, through a prefetch FIFO to the LCD timing stage. It also owns
//   the buffer-select handshake with the renderer. 'stat' names the buffer on
//   screen, and it only follows 'swap' at a frame boundary, once every read of
//   the old buffer has returned.
//
// Ports
//   clkSYS, n_reset   system clock, asynchronous active-low reset
//   swap              renderer's last-completed buffer flag
//   stat              buffer currently scanned out
//   addr/data/req/wr  read request to the memory arbiter (data=0, wr=0)
//   ack               arbiter accepted the current request
//   mem/valid         returned read word, in issue order
//   px_data/px_sof    FIFO head pixel and start-of-frame marker
//   px_valid/px_ready pixel stream handshake
//   underrun          sticky: px_ready seen while the FIFO was empty
//
// State table
//   FETCH | issue reads of the current frame
//   DRAIN | all reads issued, waiting for outstanding returns
//   SWAP  | one cycle: latch swap into stat and restart the frame
module display_scanout #(
  parameter logic [23:0] BASE  = 24'h000000,
  parameter int          W     = 800,
  parameter int          H     = 480,
  parameter int          DEPTH = 32
) (
  input  logic        clkSYS,
  input  logic        n_reset,
  input  logic        swap,
  output logic        stat,
  input  logic [15:0] mem,
  input  logic        valid,
  output logic [23:0] addr,
  output logic [15:0] data,
  output logic        req,
  output logic        wr,
  input  logic        ack,
  output logic [15:0] px_data,
  output logic        px_sof,
  output logic        px_valid,
  input  logic        px_ready,
  output logic        underrun
);

  localparam int          AW   = $clog2(DEPTH);
  localparam int          CW   = AW + 2;
  localparam logic [23:0] LAST = 24'(W * H - 1);

  typedef enum logic [1:0] {FETCH, DRAIN, SWAP} state_t;

  state_t        state, state_nx;
  logic [23:0]   icnt;
  logic [23:0]   rcnt;
  logic [AW:0]   outstanding;
  logic [AW:0]   fifo_count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [16:0]   fifo_mem [DEPTH];
  logic          last_issued;
  logic          ack_ok, push, pop, full, req_nx;
  logic [CW-1:0] cred, cred_lim;

  assign ack_ok = ack & req;
  // After reset outstanding is 0, so late returns of pre-reset reads are dropped.
  assign push   = valid & (outstanding != '0);
  assign pop    = px_valid & px_ready;
  assign full   = (fifo_count == (AW+1)'(DEPTH));

  // cred counts the request currently on the bus, so a held request is
  // already paid for; the limit is raised by the same amount so that an
  // unacknowledged req is never withdrawn while its slot is reserved.
  assign cred     = CW'(outstanding) + CW'(fifo_count) + CW'(req);
  assign cred_lim = CW'(DEPTH) + CW'(req);
  assign req_nx   = (state == FETCH) & ~ack & (cred < cred_lim) & ~last_issued;

  assign addr     = BASE + (stat ? 24'h080000 : 24'h000000) + icnt;
  assign data     = 16'h0;
  assign wr       = 1'b0;
  assign px_valid = (fifo_count != '0);
  assign px_data  = fifo_mem[rd_ptr][15:0];
  assign px_sof   = fifo_mem[rd_ptr][16];

  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) state <= FETCH;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   if (ack_ok && icnt == LAST) state_nx = DRAIN;
      DRAIN:   if (outstanding == '0) state_nx = SWAP;
      SWAP:    state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      req         <= 1'b0;
      stat        <= 1'b0;
      icnt        <= '0;
      rcnt        <= '0;
      last_issued <= 1'b0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      underrun    <= 1'b0;
    end else begin
      req <= req_nx;

      if (state == SWAP) begin
        stat        <= swap;
        icnt        <= '0;
        last_issued <= 1'b0;
      end else if (ack_ok) begin
        if (icnt == LAST) begin
          icnt        <= '0;
          last_issued <= 1'b1;
        end else begin
          icnt <= icnt + 24'd1;
        end
      end

      case ({ack_ok, push})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rcnt   <= (rcnt == LAST) ? '0 : rcnt + 24'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      if (px_ready && !px_valid) underrun <= 1'b1;
    end
  end

  always_ff @(posedge clkSYS) begin
    if (push) fifo_mem[wr_ptr] <= {(rcnt == '0), mem};
  end

  // Credit accounting must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clkSYS) disable iff (!n_reset)
                                  !(push && full && !pop));

endmodule

// File: tb/tb_display_scanout.sv
module tb_display_scanout;

  localparam int          W     = 16;
  localparam int          H     = 2;
  localparam int          DEPTH = 8;
  localparam int          NPIX  = W * H;
  localparam logic [23:0] BASE  = 24'h000000;

  logic        clkSYS = 1'b0;
  logic        n_reset = 1'b0;
  logic        swap = 1'b0;
  logic [15:0] mem = 16'h0;
  logic        valid = 1'b0;
  logic        ack = 1'b0;
  logic        px_ready = 1'b0;
  logic        stat, req, wr, px_sof, px_valid, underrun;
  logic [23:0] addr;
  logic [15:0] data, px_data;

  always #5 clkSYS = ~clkSYS;

  display_scanout #(.BASE(BASE), .W(W), .H(H), .DEPTH(DEPTH)) dut (
    .clkSYS(clkSYS), .n_reset(n_reset), .swap(swap), .stat(stat),
    .mem(mem), .valid(valid), .addr(addr), .data(data), .req(req),
    .wr(wr), .ack(ack), .px_data(px_data), .px_sof(px_sof),
    .px_valid(px_valid), .px_ready(px_ready), .underrun(underrun)
  );

  typedef struct { int due; logic [15:0] d; } ret_t;

  int   tests = 0, fails = 0;
  int   cyc = 0, lat = 3, rdy_mode = 0, sw_mode = 0;
  bit   req_prev = 0;
  ret_t rq[$];
  // Reference model: counts of words in flight / buffered, frame buffer choice
  // per frame, and issue/pop positions (frame, pixel index).
  int   out_m, fifo_m, f_iss, i_iss, f_pop, i_pop, n_acks, n_pops, coinc;
  bit   und_m;
  bit   fbuf[$];

  // Memory contents: distinct per buffer so a wrong buffer shows in the data.
  function automatic logic [15:0] mem_fn(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], 8'h00};
  endfunction

  function automatic logic [23:0] exp_addr(input bit b, input int i);
    return BASE + (b ? 24'h080000 : 24'h000000) + 24'(i);
  endfunction

  // One clock: sample at negedge, model the arbiter/memory/LCD, drive inputs.
  task automatic step(input bit in_rst);
    bit          do_ack, do_vld, do_pop, acc;
    logic [15:0] rdata, pexp;
    @(negedge clkSYS);
    cyc++;
    if (!in_rst) begin
      tests++;
      if (px_valid !== (fifo_m != 0)) begin
        fails++; $display("FAIL px_valid cyc %0d: got %b want %b", cyc, px_valid, fifo_m != 0);
      end
      tests++;
      if (underrun !== und_m) begin
        fails++; $display("FAIL underrun cyc %0d: got %b want %b", cyc, underrun, und_m);
      end
      tests++;
      if (data !== 16'h0 || wr !== 1'b0) begin
        fails++; $display("FAIL const_outs cyc %0d: data %h wr %b want 0 0", cyc, data, wr);
      end
    end

    do_ack   = !in_rst && (req === 1'b1) && req_prev;
    req_prev = !in_rst && (req === 1'b1);

    do_vld = (rq.size() > 0) && (rq[0].due <= cyc);
    if (do_vld) begin
      rdata = rq[0].d; rq.pop_front();
      valid = 1'b1; mem = rdata;
    end else begin
      valid = 1'b0; mem = 16'($urandom);
    end
    acc = do_vld && !in_rst && (out_m > 0);

    case (rdy_mode)
      0:       px_ready = 1'b0;
      1:       px_ready = 1'b1;
      default: px_ready = 1'($urandom_range(0, 1));
    endcase
    if (in_rst) px_ready = 1'b0;

    do_pop = px_ready && (fifo_m > 0);
    if (do_pop) begin
      pexp = mem_fn(exp_addr(fbuf[f_pop], i_pop));
      tests++;
      if (px_data !== pexp || px_sof !== (i_pop == 0)) begin
        fails++;
        $display("FAIL pixel f%0d i%0d: got %h sof %b want %h sof %b",
                 f_pop, i_pop, px_data, px_sof, pexp, i_pop == 0);
      end
      n_pops++; i_pop++;
      if (i_pop == NPIX) begin i_pop = 0; f_pop++; end
    end
    if (px_ready && fifo_m == 0) und_m = 1'b1;

    if (do_ack) begin
      tests++;
      if (addr !== exp_addr(fbuf[f_iss], i_iss)) begin
        fails++;
        $display("FAIL addr f%0d i%0d: got %h want %h", f_iss, i_iss, addr, exp_addr(fbuf[f_iss], i_iss));
      end
      tests++;
      if (stat !== fbuf[f_iss]) begin
        fails++; $display("FAIL stat f%0d: got %b want %b", f_iss, stat, fbuf[f_iss]);
      end
      rq.push_back('{cyc + lat, mem_fn(addr)});
      n_acks++; i_iss++;
      if (i_iss == 11) begin
        if (sw_mode == 1) swap = 1'($urandom_range(0, 1));
        else if (sw_mode == 2) swap = 1'b1;
        fbuf.push_back(swap);
      end
      if (i_iss == NPIX) begin i_iss = 0; f_iss++; end
    end
    ack = do_ack;
    if (do_ack && do_vld) coinc++;

    out_m  = out_m + int'(do_ack) - int'(acc);
    fifo_m = fifo_m + int'(acc) - int'(do_pop);
    tests++;
    if (out_m > DEPTH || fifo_m > DEPTH) begin
      fails++; $display("FAIL credit cyc %0d: outstanding %0d fifo %0d limit %0d", cyc, out_m, fifo_m, DEPTH);
    end
  endtask

  task automatic do_reset(input bit keep_inflight);
    n_reset = 1'b0;
    ack = 1'b0; px_ready = 1'b0; swap = 1'b0; req_prev = 0;
    if (!keep_inflight) begin rq.delete(); valid = 1'b0; end
    out_m = 0; fifo_m = 0; und_m = 0;
    f_iss = 0; i_iss = 0; f_pop = 0; i_pop = 0; n_acks = 0; n_pops = 0; coinc = 0;
    fbuf.delete(); fbuf.push_back(1'b0);
    step(1); step(1);
    tests++;
    if (req !== 1'b0 || stat !== 1'b0) begin
      fails++; $display("FAIL reset_req_stat: got req %b stat %b want 0 0", req, stat);
    end
    tests++;
    if (px_valid !== 1'b0 || underrun !== 1'b0) begin
      fails++; $display("FAIL reset_fifo: got px_valid %b underrun %b want 0 0", px_valid, underrun);
    end
    n_reset = 1'b1;
  endtask

  task automatic test_reset();
    lat = 3; rdy_mode = 0; sw_mode = 0;
    do_reset(0);
    step(0);
    tests++;
    if (req !== 1'b1 || addr !== BASE) begin
      fails++; $display("FAIL first_req: got req %b addr %h want 1 %h", req, addr, BASE);
    end
  endtask

  task automatic test_in_order();
    int n = 0;
    lat = 3; rdy_mode = 2; sw_mode = 0;
    do_reset(0);
    while (n_pops < NPIX && n < 500) begin step(0); n++; end
    tests++;
    if (n_pops < NPIX) begin
      fails++; $display("FAIL in_order_timeout: popped %0d want %0d", n_pops, NPIX);
    end
  endtask

  task automatic test_backpressure();
    lat = 3; rdy_mode = 0; sw_mode = 0;
    do_reset(0);
    repeat (100) step(0);
    tests++;
    if (n_acks != DEPTH) begin
      fails++; $display("FAIL bp_acks: got %0d want %0d", n_acks, DEPTH);
    end
    tests++;
    if (req !== 1'b0 || px_valid !== 1'b1 || underrun !== 1'b0) begin
      fails++; $display("FAIL bp_state: got req %b px_valid %b underrun %b want 0 1 0", req, px_valid, underrun);
    end
    tests++;
    if (out_m != 0 || rq.size() != 0) begin
      fails++; $display("FAIL bp_outstanding: got %0d pending %0d want 0 0", out_m, rq.size());
    end
    rdy_mode = 2;
    repeat (300) step(0);
    tests++;
    if (n_pops < NPIX) begin
      fails++; $display("FAIL bp_resume: popped %0d want >= %0d", n_pops, NPIX);
    end
  endtask

  task automatic test_swap();
    int n = 0;
    lat = 3; rdy_mode = 1; sw_mode = 2;
    do_reset(0);
    while (f_pop < 2 && n < 800) begin step(0); n++; end
    tests++;
    if (f_pop < 2 || stat !== 1'b1) begin
      fails++; $display("FAIL swap_frames: got frames %0d stat %b want >=2 1", f_pop, stat);
    end
  endtask

  task automatic test_back_to_back();
    lat = 3; rdy_mode = 1; sw_mode = 1;
    do_reset(0);
    repeat (1500) step(0);
    tests++;
    if (coinc == 0 || n_pops < 3 * NPIX) begin
      fails++; $display("FAIL b2b: got coincident %0d pops %0d want >0 >=%0d", coinc, n_pops, 3 * NPIX);
    end
  endtask

  task automatic test_latency();
    lat = 20; rdy_mode = 1; sw_mode = 1;
    do_reset(0);
    repeat (700) step(0);
    tests++;
    if (underrun !== 1'b1 || f_pop < 2) begin
      fails++; $display("FAIL latency: got underrun %b frames %0d want 1 >=2", underrun, f_pop);
    end
    lat = 3;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    lat = 3; rdy_mode = 2; sw_mode = 0;
    do_reset(0);
    while (n_acks < 10 && n < 200) begin step(0); n++; end
    tests++;
    if (n_acks < 10) begin
      fails++; $display("FAIL mid_acks_timeout: got %0d want 10", n_acks);
    end
    step(0);
    do_reset(1);
    n = 0;
    while (n_pops < 1 && n < 100) begin step(0); n++; end
    tests++;
    if (n_pops < 1 || n_acks < 1) begin
      fails++; $display("FAIL mid_restart: got pops %0d acks %0d want >=1 >=1", n_pops, n_acks);
    end
    repeat (200) step(0);
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_backpressure();
    test_swap();
    test_back_to_back();
    test_latency();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
